// File: rtl/ram_init_if.sv
// Request/response bundle for ram_init: the master issues accesses and clear requests,
// the slave (the RAM) returns registered read data with valid/err/busy qualifiers.
interface ram_init_if #(
  parameter int width = 8,
  parameter int adr_w = 4
);
  logic             en;
  logic             w;
  logic [width-1:0] in;
  logic [adr_w-1:0] adr;
  logic             clr;
  logic [width-1:0] out;
  logic             valid;
  logic             busy;
  logic             err;

  modport master (output en, w, in, adr, clr, input out, valid, busy, err);
  modport slave  (input en, w, in, adr, clr, output out, valid, busy, err);
endinterface

// File: rtl/ram_init.sv
// Single-port RAM with registered valid-qualified reads, out-of-range flagging and an
// optional init_val clear sweep after reset or on clr (built only when RAM_CLEAR_EN is defined).
//
// state | meaning
// CLR   | sweep writing init_val to mem[cnt], busy = 1, accesses discarded
// RUN   | normal read/write access
module ram_init #(
  parameter int               width    = 8,
  parameter int               adr_w    = 4,
  parameter int               size     = 8,
  parameter logic [width-1:0] init_val = '0
) (
  input  logic     clk,
  input  logic     rst,
  ram_init_if.slave bus
);
  localparam int               DEPTH    = 1 << adr_w;
  localparam logic [adr_w:0]   SIZE_W   = (adr_w + 1)'(size);
  localparam logic [adr_w-1:0] CNT_LAST = adr_w'(size - 1);

  typedef enum logic {CLR, RUN} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [width-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [adr_w-1:0] mem_wadr;
  logic [width-1:0] mem_wdata;
  logic             in_range;
  logic             clr_req;

`ifdef RAM_CLEAR_EN
  logic [adr_w-1:0] cnt_q, cnt_d;
  assign clr_req  = bus.clr;
  assign bus.busy = (state_q == CLR);
`else
  logic unused_clr;
  assign unused_clr = bus.clr;
  assign clr_req    = 1'b0;
  assign bus.busy   = 1'b0;
`endif

  assign in_range = ({1'b0, bus.adr} < SIZE_W);

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_wadr  = bus.adr;
    mem_wdata = bus.in;
`ifdef RAM_CLEAR_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      CLR: begin
`ifdef RAM_CLEAR_EN
        if (clr_req) begin
          cnt_d = '0;
        end else begin
          mem_we    = 1'b1;
          mem_wadr  = cnt_q;
          mem_wdata = init_val;
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + adr_w'(1);
          end
        end
`endif
      end
      RUN: begin
        // clr wins over a simultaneous access, which is dropped
        if (clr_req) begin
          state_d = CLR;
`ifdef RAM_CLEAR_EN
          cnt_d   = '0;
`endif
        end else if (bus.en) begin
          err_d = ~in_range;
          if (bus.w) begin
            mem_we = in_range;
          end else begin
            valid_d = 1'b1;
            out_d   = in_range ? mem_q[bus.adr] : '0;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef RAM_CLEAR_EN
      state_q <= CLR;
      cnt_q   <= '0;
`else
      state_q <= RUN;
`endif
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef RAM_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // storage is not reset; its contents are defined only by the sweep or by writes
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wadr] <= mem_wdata;
  end

  assign bus.out   = out_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_ram_init.sv
// Scoreboard bench for ram_init: a word-level memory model predicts each access response
// into a queue; a negedge monitor pops and compares whenever the RAM presents valid or err.
module tb_ram_init;
  localparam int W = 8, AW = 4, SZ = 8;
  localparam logic [7:0] INIT = 8'h00;
`ifdef RAM_CLEAR_EN
  localparam bit CLR_BUILD = 1'b1;
`else
  localparam bit CLR_BUILD = 1'b0;
`endif

  typedef struct {
    logic       vld;
    logic       er;
    logic [7:0] d;
    bit         known;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_init_if #(.width(W), .adr_w(AW)) bus ();
  ram_init #(.width(W), .adr_w(AW), .size(SZ), .init_val(INIT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_mem   [SZ];
  bit         m_known [SZ];
  int         m_busy;
  logic [7:0] m_last;
  bit         m_last_known;

  task automatic model_reset();
    m_busy       = CLR_BUILD ? SZ : 0;
    m_last       = 8'h00;
    m_last_known = 1'b1;
    for (int i = 0; i < SZ; i++) m_known[i] = 1'b0;
  endtask

  task automatic check_rst_vals(input string tag);
    checks++;
    if (bus.out !== 8'h00 || bus.valid !== 1'b0 || bus.err !== 1'b0 || bus.busy !== CLR_BUILD) begin
      failures++;
      $display("FAIL %s: out=%h valid=%b err=%b busy=%b, required out=00 valid=0 err=0 busy=%b",
               tag, bus.out, bus.valid, bus.err, bus.busy, CLR_BUILD);
    end
  endtask

  // One clock edge with the currently driven request; model predicts, then busy is checked.
  task automatic tick();
    exp_t e;
    bool_in_range: begin end
    if (m_busy > 0) begin
      if (bus.clr) m_busy = SZ;
      else begin
        m_busy--;
        if (m_busy == 0) for (int i = 0; i < SZ; i++) begin m_mem[i] = INIT; m_known[i] = 1'b1; end
      end
    end else if (CLR_BUILD && bus.clr) begin
      m_busy = SZ;
    end else if (bus.en) begin
      if (bus.w) begin
        if (int'(bus.adr) < SZ) begin
          m_mem[bus.adr] = bus.in; m_known[bus.adr] = 1'b1;
        end else begin
          e.vld = 1'b0; e.er = 1'b1; e.d = m_last; e.known = m_last_known;
          exp_q.push_back(e);
        end
      end else begin
        e.vld = 1'b1;
        if (int'(bus.adr) < SZ) begin
          e.er = 1'b0; e.d = m_mem[bus.adr]; e.known = m_known[bus.adr];
        end else begin
          e.er = 1'b1; e.d = 8'h00; e.known = 1'b1;
        end
        exp_q.push_back(e);
        m_last = e.d; m_last_known = e.known;
      end
    end
    @(posedge clk); #1;
    bus.en = 1'b0; bus.clr = 1'b0;
    checks++;
    if (bus.busy !== (m_busy > 0)) begin
      failures++;
      $display("FAIL busy: got %b, required %b", bus.busy, (m_busy > 0));
    end
  endtask

  task automatic acc(input logic wr, input logic [3:0] a, input logic [7:0] d);
    bus.en = 1'b1; bus.w = wr; bus.adr = a; bus.in = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    check_rst_vals("reset_values");
    model_reset();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.valid === 1'b1 || bus.err === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: valid=%b err=%b out=%h, required no response", bus.valid, bus.err, bus.out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.valid !== e.vld || bus.err !== e.er || (e.known && bus.out !== e.d)) begin
          failures++;
          $display("FAIL response: valid=%b err=%b out=%h, required valid=%b err=%b out=%h",
                   bus.valid, bus.err, bus.out, e.vld, e.er, e.d);
        end
      end
    end
  end

  initial begin
    bus.en = 1'b0; bus.w = 1'b0; bus.in = '0; bus.adr = '0; bus.clr = 1'b0;
    @(posedge clk); #1;
    check_rst_vals("reset_values");
    model_reset();
    rst = 1'b0;
    idle(SZ + 1);
    for (int i = 0; i < SZ; i++) acc(1'b0, 4'(i), 8'h00);
    for (int i = 0; i < SZ; i++) acc(1'b1, 4'(i), 8'((i + 1) * 8'h11));
    for (int i = 0; i < SZ; i++) acc(1'b0, 4'(i), 8'h00);
    acc(1'b1, 4'd9, 8'hAA);
    idle(1);
    acc(1'b0, 4'd9, 8'h00);
    acc(1'b0, 4'd1, 8'h00);
    acc(1'b0, 4'd15, 8'h00);
    idle(1);
    // clear request with a simultaneous write that must be dropped
    bus.clr = 1'b1;
    acc(1'b1, 4'd3, 8'h55);
    acc(1'b0, 4'd2, 8'h00);
    idle(SZ);
    acc(1'b0, 4'd3, 8'h00);
    acc(1'b1, 4'd6, 8'h77);
    acc(1'b0, 4'd6, 8'h00);
    idle(1);
    bus.clr = 1'b1;
    tick();
    idle(3);
    bus.clr = 1'b1;
    tick();
    idle(4);
    do_reset();
    idle(SZ + 1);
    for (int i = 0; i < SZ; i++) acc(1'b0, 4'(i), 8'h00);
    for (int n = 0; n < 400; n++) begin
      bus.clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) != 0) acc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
      else tick();
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_responses: %0d left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
